ws2812_pixel_rx: RTL

Receive-side decoder for the WS2812B single-wire NZR stream produced by the GRB shipping logic. Samples the serial line, classifies each high pulse as a 0 or 1 bit, assembles 24-bit GRB words (MSB first), reports each pixel with its index in the frame, and detects the >280 µs reset gap as end-of-frame. Used as a loopback checker and LED-strip emulator on the 100 MHz fabric clock (10 ns/tick).

---
 rtl/ws2812_pixel_rx.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ws2812_pixel_rx.sv
// rtl/ws2812_pixel_rx.sv - WS2812B NZR receive decoder: GRB pixels, frame end, timing errors
// Define WS_RX_GLITCH_FILTER_EN to insert a 3-sample majority filter after the synchronizer.
module ws2812_pixel_rx #(
  parameter int T_MIN_HIGH = 10,
  parameter int T_THRESH   = 60,
  parameter int T_HIGH_MAX = 100,
  parameter int T_RESET    = 28100,
  parameter int MAX_PIXELS = 300
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic        pix_valid,
  output logic [23:0] pix_grb,
  output logic [8:0]  pix_index,
  output logic        frame_done,
  output logic [8:0]  frame_pixels,
  output logic        bit_err,
  output logic        overflow
);

  localparam logic [14:0] LCNT_END = 15'(T_RESET - 1);
  localparam logic [6:0]  HMIN     = 7'(T_MIN_HIGH);
  localparam logic [6:0]  HTH      = 7'(T_THRESH);
  localparam logic [6:0]  HMAX     = 7'(T_HIGH_MAX);
  localparam logic [8:0]  PIX_MAX  = 9'(MAX_PIXELS);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  state_t      state, state_n;
  logic        s1, s2, s3;
  logic        line, line_d;
  logic        rise;
  logic [14:0] lcnt;
  logic [6:0]  hcnt;
  logic [4:0]  bit_cnt;
  logic [8:0]  pix_cnt;
  logic [22:0] shift;
  logic        take_bit, err, frame_end, bit_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

`ifdef WS_RX_GLITCH_FILTER_EN
  // Majority over s2/s3/g2, registered: pulse widths >= 2 pass unchanged, 1-clk events vanish.
  logic g2;
  always_ff @(posedge clk) begin
    if (reset) begin
      g2     <= 1'b0;
      line   <= 1'b0;
      line_d <= 1'b0;
    end else begin
      g2     <= s3;
      line   <= (s2 & s3) | (s2 & g2) | (s3 & g2);
      line_d <= line;
    end
  end
`else
  assign line   = s2;
  assign line_d = s3;
`endif

  assign rise    = line & ~line_d;
  assign bit_val = (hcnt >= HTH);

  always_ff @(posedge clk) begin
    if (reset) state <= SYNC;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    take_bit  = 1'b0;
    err       = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      SYNC: if (!line && lcnt == LCNT_END) state_n = IDLE;
      IDLE: if (rise) state_n = HIGH;
      HIGH: begin
        if (line) begin
          if (hcnt >= HMAX) begin
            err     = 1'b1;
            state_n = SYNC;
          end
        end else if (hcnt < HMIN) begin
          err     = 1'b1;
          state_n = SYNC;
        end else begin
          take_bit = 1'b1;
          state_n  = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_n = HIGH;
        end else if (lcnt == LCNT_END) begin
          frame_end = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcnt         <= '0;
      hcnt         <= '0;
      bit_cnt      <= '0;
      pix_cnt      <= '0;
      shift        <= '0;
      pix_valid    <= 1'b0;
      pix_grb      <= '0;
      pix_index    <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      bit_err      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      bit_err    <= err | (frame_end && bit_cnt != 5'd0);
      case (state)
        SYNC: begin
          bit_cnt <= '0;
          pix_cnt <= '0;
          if (line)                  lcnt <= '0;
          else if (lcnt != LCNT_END) lcnt <= lcnt + 15'd1;
        end
        IDLE: begin
          if (rise) hcnt <= 7'd1;
        end
        HIGH: begin
          if (line) hcnt <= hcnt + 7'd1;
          if (err)  lcnt <= '0;
          if (take_bit) begin
            lcnt  <= 15'd1;
            shift <= {shift[21:0], bit_val};
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              if (pix_cnt < PIX_MAX) begin
                pix_valid <= 1'b1;
                pix_grb   <= {shift, bit_val};
                pix_index <= pix_cnt;
                pix_cnt   <= pix_cnt + 9'd1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        LOW: begin
          if (rise)          hcnt <= 7'd1;
          if (lcnt != '1)    lcnt <= lcnt + 15'd1;
          // Partial pixel bits are simply dropped; bit_err above reports them.
          if (frame_end) begin
            frame_done   <= 1'b1;
            frame_pixels <= pix_cnt;
            overflow     <= 1'b0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
